sha256_msg_schedule: RTL

Downstream consumer of the SHA-256 padding stage in the Bitcoin hashing datapath.
- Accepts one padded 512-bit block at a time.
- Expands the block into the 64-word message schedule W[0..63].
- Streams one 32-bit word per cycle, with backpressure, to the compression round engine.
- Uses a 16-word sliding window, so it never stores all 64 words.

---
 rtl/sha256_msg_schedule_pkg.sv | 32 +++
 rtl/sha256_w_expand.sv | 15 +
 rtl/sha256_msg_schedule.sv | 96 +++++++++
 3 files changed

// File: rtl/sha256_msg_schedule_pkg.sv
// Shared SHA-256 widths, schedule FSM encodings and the sigma functions,
// kept here so the compression engine can reuse the same definitions.
package sha256_msg_schedule_pkg;

  localparam int SHA256_WORD_W  = 32;
  localparam int SHA256_BLOCK_W = 512;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic [SHA256_WORD_W-1:0] rotr(input logic [SHA256_WORD_W-1:0] x,
                                                    input int n);
    return (x >> n) | (x << (SHA256_WORD_W - n));
  endfunction

  function automatic logic [SHA256_WORD_W-1:0] sig0(input logic [SHA256_WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [SHA256_WORD_W-1:0] sig1(input logic [SHA256_WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [SHA256_WORD_W-1:0] Sig0(input logic [SHA256_WORD_W-1:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [SHA256_WORD_W-1:0] Sig1(input logic [SHA256_WORD_W-1:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational expansion step: next schedule word from the sliding window,
// W[t+16] = sig1(W[t+14]) + W[t+9] + sig0(W[t+1]) + W[t], modulo 2^32.
module sha256_w_expand
  import sha256_msg_schedule_pkg::*;
(
  input  logic [SHA256_WORD_W-1:0] w0_i,
  input  logic [SHA256_WORD_W-1:0] w1_i,
  input  logic [SHA256_WORD_W-1:0] w9_i,
  input  logic [SHA256_WORD_W-1:0] w14_i,
  output logic [SHA256_WORD_W-1:0] w_next_o
);

  assign w_next_o = sig1(w14_i) + w9_i + sig0(w1_i) + w0_i;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: accepts one padded block, then streams W[0..ROUNDS-1]
// one word per handshake using a 16-word sliding window.
//
// state | meaning
// IDLE  | waiting for a block, blk_ready high
// RUN   | streaming window head as W[t], w_valid high
module sha256_msg_schedule
  import sha256_msg_schedule_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic                      CLK,
  input  logic                      nreset,
  input  logic                      blk_valid,
  output logic                      blk_ready,
  input  logic [SHA256_BLOCK_W-1:0] blk_data,
  input  logic                      flush,
  output logic                      w_valid,
  input  logic                      w_ready,
  output logic [SHA256_WORD_W-1:0]  w_data,
  output logic [5:0]                w_idx,
  output logic                      w_last
);

  localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

  logic [0:0]               state_q, state_d;
  logic [5:0]               t_q, t_d;
  logic [SHA256_WORD_W-1:0] win_q [16];
  logic [SHA256_WORD_W-1:0] win_d [16];
  logic [SHA256_WORD_W-1:0] w_next;

  sha256_w_expand u_expand (
    .w0_i     (win_q[0]),
    .w1_i     (win_q[1]),
    .w9_i     (win_q[9]),
    .w14_i    (win_q[14]),
    .w_next_o (w_next)
  );

  assign blk_ready = (state_q == ST_IDLE);
  assign w_valid   = (state_q == ST_RUN);
  assign w_data    = win_q[0];
  assign w_idx     = t_q;
  assign w_last    = w_valid && (t_q == T_LAST);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    win_d   = win_q;
    // flush wins over any handshake presented in the same cycle
    if (flush) begin
      state_d = ST_IDLE;
      t_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (blk_valid) begin
            for (int i = 0; i < 16; i++) begin
              win_d[i] = blk_data[SHA256_BLOCK_W-1-SHA256_WORD_W*i -: SHA256_WORD_W];
            end
            t_d     = '0;
            state_d = ST_RUN;
          end
        end
        default: begin
          if (w_ready) begin
            if (t_q == T_LAST) begin
              state_d = ST_IDLE;
              t_d     = '0;
            end else begin
              for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i+1];
              end
              win_d[15] = w_next;
              t_d       = t_q + 6'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      win_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      win_q   <= win_d;
    end
  end

endmodule
